// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op codes, slice mux selects, FSM states.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // SUB and SLT both subtract: invert b and seed the carry with 1.
  function automatic logic op_binv(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic [1:0] op_sel(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_OR:                  sel = SEL_OR;
      OP_ADD, OP_SUB, OP_SLT: sel = SEL_SUM;
      default:                sel = SEL_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit MIPS ALU slice: AND, OR, full adder and a 4:1 result mux.
module alu_bit_slice
  import alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [1:0] sel,
  output logic       result,
  output logic       cout
);

  logic sum;

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

  always_comb begin
    result = 1'b0;
    case (sel)
      SEL_AND:  result = a & b;
      SEL_OR:   result = a | b;
      SEL_SUM:  result = sum;
      SEL_LESS: result = less;
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one slice, one bit per clock, LSB first, start/busy/done handshake.
// Optional abort input enabled by defining ALU_SERIAL_ABORT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start; operands/op latched on start
// ST_RUN    | one bit per clock through the slice, carry chained in carry_q
// ST_FINISH | flags, SLT fix-up and done pulse; back to idle
module alu_serial_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;

  logic             slice_b, slice_less, slice_res, slice_cout;
  logic [1:0]       slice_sel;
  logic             legal, add_ovf;
  logic [WIDTH-1:0] fin_res;

  alu_bit_slice u_slice (
    .a      (a_q[0]),
    .b      (slice_b),
    .cin    (carry_q),
    .less   (slice_less),
    .sel    (slice_sel),
    .result (slice_res),
    .cout   (slice_cout)
  );

  assign legal   = op_is_legal(op_q);
  assign add_ovf = cin_msb_q ^ carry_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    bit_idx_d  = bit_idx_q;
    carry_d    = carry_q;
    cin_msb_d  = cin_msb_q;
    done_d     = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    slice_b    = b_q[0] ^ op_binv(op_q);
    slice_sel  = op_sel(op_q);
    slice_less = 1'b0;
    fin_res    = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          op_d      = op;
          a_d       = a;
          b_d       = b;
          bit_idx_d = '0;
          carry_d   = op_binv(op);
        end
      end
      ST_RUN: begin
        acc_d     = {slice_res & legal, acc_q[WIDTH-1:1]};
        a_d       = a_q >> 1;
        b_d       = b_q >> 1;
        carry_d   = slice_cout;
        bit_idx_d = bit_idx_q + IDX_W'(1);
        if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
          cin_msb_d = carry_q;
          bit_idx_d = '0;
          state_d   = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // The slice's less input rebuilds bit 0 for SLT: sign of (a-b) corrected by overflow.
        slice_sel  = SEL_LESS;
        slice_less = acc_q[WIDTH-1] ^ add_ovf;
        if (!legal) begin
          fin_res    = '0;
          overflow_d = 1'b0;
        end else if (op_q == OP_SLT) begin
          fin_res    = '0;
          fin_res[0] = slice_res;
          overflow_d = add_ovf;
        end else begin
          overflow_d = (op_q == OP_ADD) || (op_q == OP_SUB) ? add_ovf : 1'b0;
        end
        result_d = fin_res;
        zero_d   = (fin_res == '0);
        err_d    = ~legal;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef ALU_SERIAL_ABORT_EN
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      bit_idx_d  = '0;
      done_d     = 1'b0;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      err_d      = err_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      bit_idx_q  <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      bit_idx_q  <= bit_idx_d;
      carry_q    <= carry_d;
      cin_msb_q  <= cin_msb_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=8: vector table plus handshake/reset/abort sequences.
module tb_alu_serial_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op_i = 3'b000;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy, done, zero, overflow, err;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef ALU_SERIAL_ABORT_EN
    .abort    (abort),
`endif
    .op       (op_i),
    .a        (a_i),
    .b        (b_i),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ovf;
    logic         e;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives a start pulse; returns 1 time unit after the start edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(output int n, output logic busy_ok);
    n = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = c;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int   n;
    logic bok;
    int   dones;
    int   done_c;
    logic [W-1:0] res_seen;

    vecs[0]  = '{3'b010, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b110, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{3'b000, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{3'b100, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'b111, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset zero", zero, 0);
    check("reset overflow", overflow, 0);
    check("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d busy after start", i), busy, 1);
      wait_done(n, bok);
      check($sformatf("v%0d latency", i), n, 9);
      check($sformatf("v%0d busy window", i), bok, 1);
      check($sformatf("v%0d result", i), result, vecs[i].res);
      check($sformatf("v%0d zero", i), zero, vecs[i].z);
      check($sformatf("v%0d overflow", i), overflow, vecs[i].ovf);
      check($sformatf("v%0d err", i), err, vecs[i].e);
      @(posedge clk);
      #1;
      check($sformatf("v%0d done pulse width", i), done, 0);
    end

    // Start pulses and operand changes mid-op are ignored.
    start_op(3'b010, 8'h35, 8'h4A);
    dones = 0;
    done_c = -1;
    res_seen = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = (c == 2) || (c == 4);
      op_i  = 3'b110;
      a_i   = 8'(c);
      b_i   = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_c = c;
          res_seen = result;
        end
      end
    end
    check("busy start dones", dones, 1);
    check("busy start latency", done_c, 9);
    check("busy start result", res_seen, 8'h7F);

    // Start accepted in the done cycle.
    start_op(3'b010, 8'h7F, 8'h01);
    wait_done(n, bok);
    check("b2b first latency", n, 9);
    check("b2b first result", result, 8'h80);
    check("b2b first overflow", overflow, 1);
    @(negedge clk);
    start = 1'b1;
    op_i  = 3'b000;
    a_i   = 8'hF0;
    b_i   = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b second busy", busy, 1);
    wait_done(n, bok);
    check("b2b second latency", n, 9);
    check("b2b second result", result, 8'hF0);
    check("b2b second overflow", overflow, 0);

    // Asynchronous reset mid-run.
    start_op(3'b010, 8'h01, 8'h01);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst zero", zero, 0);
    check("rst overflow", overflow, 0);
    check("rst err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("rst no done", dones, 0);
    start_op(3'b010, 8'h12, 8'h34);
    wait_done(n, bok);
    check("post rst latency", n, 9);
    check("post rst result", result, 8'h46);

`ifdef ALU_SERIAL_ABORT_EN
    start_op(3'b110, 8'h10, 8'h20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort no done", dones, 0);
    check("abort result held", result, 8'h46);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    op_i  = 3'b001;
    a_i   = 8'h0F;
    b_i   = 8'h30;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort+start busy", busy, 1);
    wait_done(n, bok);
    check("abort+start latency", n, 9);
    check("abort+start result", result, 8'h3F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer for the MIPS datapath.
- Latches two WIDTH-bit operands and a MIPS ALU-control code, then drives one 1-bit ALU slice (AND/OR/full-adder plus a 4:1 result mux) for one bit per clock.
- Handles carry chaining, subtract inversion, set-on-less-than fix-up, zero and overflow flags.
- Sits between the control unit and the register-file write-back; uses a start/busy/done handshake.

Parameters:
- WIDTH, 32: operand/result width in bits; legal 2..64.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result/flags valid.
- result  output  WIDTH  registered result; held until the next done.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow for ADD/SUB/SLT; 0 for AND/OR.
- err  output  1  with done: op was not a legal code.

Behaviour:
- Reset: state=IDLE; busy, done, result, zero, overflow and err all 0; bit index=0; carry=0. Reset is asynchronous and may occur mid-operation: it aborts with no done.
- States: IDLE -> RUN -> FINISH -> IDLE.
- IDLE, start=1 at edge k:
  - latch a, b, op;
  - bit index=0;
  - carry = 1 for SUB/SLT, else 0;
  - busy=1 from edge k.
- RUN:
  - Each edge processes bit i: slice inputs a[i], b[i]^binv (binv=1 for SUB/SLT), carry.
  - Mux select: AND=00, OR=01, ADD/SUB/SLT=10. Select 11 (less) is used only for bit 0 in FINISH.
  - Slice output is shifted into the partial result at bit i; carry <= slice carry-out.
  - At i=WIDTH-1, also capture carry-in of the MSB for overflow. Go to FINISH.
- FINISH (edge k+WIDTH+1):
  - overflow = carry_in_msb ^ carry_out_msb for ADD/SUB/SLT.
  - SLT: result = {WIDTH-1 zeros, sum_msb ^ overflow}; SLT overflow output = the subtract overflow.
  - zero computed on the final result; done=1; busy=0.
  - Return to IDLE.
- Latency: done asserted exactly WIDTH+1 cycles after the start edge. Back-to-back start is accepted in the cycle done is high, because the state is then IDLE.
- start while busy: ignored, with no queuing. Operand/op changes while busy have no effect.
- Illegal op: run the full WIDTH cycles with the slice output forced to 0. At done: result=0, zero=1, overflow=0, err=1.
- err is 0 on every legal completion. result, zero, overflow and err are updated only at done.

Optional Feature:
- ALU_SERIAL_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN or FINISH: go to IDLE next edge, busy=0, no done pulse, and result/flags keep their previous values.
  - abort in IDLE is ignored. If abort and start are both high in IDLE, start wins.
- Not defined: no abort port; an operation always runs to completion.

Decomposition:
- Package alu_ctrl_pkg:
  - op encodings (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT);
  - mux select constants (SEL_AND=2'b00, SEL_OR=2'b01, SEL_SUM=2'b10, SEL_LESS=2'b11);
  - state encoding (IDLE, RUN, FINISH).
- One sub-module, alu_bit_slice: combinational; inputs a, b, cin, less, sel[1:0]; outputs result, cout. Instantiated once.

Test Plan (WIDTH=8):
- ADD a=8'h35 b=8'h4A, start pulse -> busy for 9 cycles, done at start+9, result=8'h7F, zero=0, overflow=0, err=0.
- ADD a=8'h7F b=8'h01 -> result=8'h80, overflow=1. SUB a=8'h10 b=8'h20 -> result=8'hF0, overflow=0.
- SLT a=8'h80 b=8'h01 -> result=8'h01. SLT a=8'h7F b=8'h80 -> result=8'h00, overflow=1.
- AND a=8'hF0 b=8'h0F -> result=8'h00, zero=1. OR same operands -> 8'hFF. Op=3'b011 -> result=0, err=1 at done.
- Start pulses at cycles 2 and 4 during one op -> only one done; operands changed mid-op do not alter the result. Start in the done cycle -> second done exactly 9 cycles later.
- rst_n low at RUN bit 3 -> all outputs 0 asynchronously, no done. Fresh ADD afterwards is correct. With ALU_SERIAL_ABORT_EN: abort at bit 5 -> busy=0 next edge, no done, previous result held.
